matmul_dma: RTL and testbench
=============================

Name: matmul_dma

Overview:
DMA responder driven by the matmul orchestration FSM. It accepts one-cycle start commands (load A, load B, store C) with a DDR base address, and moves N*N 32-bit words over an Avalon-MM master. Loads go from DDR into the on-chip A/B buffers. Stores go from the on-chip C buffer out to DDR. It reports busy and a one-cycle done pulse per transfer.

Parameters:
- N, 16: matrix dimension. Each transfer is N*N words.
- DATA_W, 32: word width. Fixed at 32, so the byte stride is 4.
- MAX_OUTSTANDING, 8: cap on read requests accepted by the fabric but not yet returned. Must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dma_start_load_a  in  1  one-cycle pulse: load A from dma_addr_a.
- dma_start_load_b  in  1  one-cycle pulse: load B from dma_addr_b.
- dma_start_store_c  in  1  one-cycle pulse: store C to dma_addr_c.
- dma_addr_a / dma_addr_b / dma_addr_c  in  32 each  DDR byte base addresses, sampled on the accepted start.
- dma_done  out  1  one-cycle pulse when the transfer completes.
- dma_busy  out  1  high while a transfer is in progress.
- avm_address  out  32  byte address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  fabric stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data valid.
- buf_wr_en  out  1  write strobe into the A/B buffers.
- buf_wr_sel  out  1  buffer select: 0 = A, 1 = B.
- buf_wr_addr  out  $clog2(N*N)  element index, row-major.
- buf_wr_data  out  32  write data.
- c_rd_addr  out  $clog2(N*N)  C buffer read index. Read data appears 1 cycle later.
- c_rd_data  in  32  C buffer read data.

Behaviour:
- Reset values: every output is 0, the state is IDLE and all counters are 0. Reset wins over every other input.
- Reset mid-transfer: next cycle the state is IDLE and avm_read/avm_write drop immediately. No dma_done is produced. Any late avm_readdatavalid is ignored.
- Start acceptance:
  - Starts are sampled only in IDLE.
  - Simultaneous starts are resolved by priority: load_a > load_b > store_c. The losers are dropped.
  - Starts that arrive while busy are ignored.
  - On acceptance, the block latches the op, latches the selected base with bits [1:0] forced to 0, and clears the counters.
- dma_busy is 1 from the cycle after acceptance through the DONE cycle.
- States: IDLE, READ, WR_FETCH, WR_DATA, DONE.
- IDLE:
  - A load start goes to READ.
  - A store start goes to WR_FETCH.
- READ:
  - issued and recvd are COUNT_W = $clog2(N*N+1) bit counters.
  - avm_read = (issued < N*N) && ((issued - recvd) < MAX_OUTSTANDING).
  - avm_address = base + 4*issued, modulo 2^32 (wraps silently).
  - issued increments when avm_read && !avm_waitrequest.
  - Each avm_readdatavalid produces buf_wr_en=1, buf_wr_addr=recvd, buf_wr_data=avm_readdata, buf_wr_sel=op, and increments recvd. This happens in the same cycle as readdatavalid, with no added latency.
  - A request issue and a data return in the same cycle are both counted.
  - Go to DONE in the cycle recvd reaches N*N.
  - avm_readdatavalid outside READ is ignored.
- WR_FETCH: drive c_rd_addr = sent and go to WR_DATA.
- WR_DATA:
  - First cycle: capture c_rd_data into the wdata register.
  - avm_write=1 with avm_address = base + 4*sent and avm_writedata = captured data.
  - Address, data and write stay stable while avm_waitrequest is high.
  - On accept (!avm_waitrequest): sent increments. If sent was N*N-1, go to DONE; otherwise go to WR_FETCH.
  - Best case is 2 cycles per word.
- DONE: dma_done=1 for exactly one cycle, then IDLE. A new start is accepted no earlier than the cycle after DONE.
- Only one transfer is ever in flight. The block never asserts avm_read and avm_write together.

Decomposition:
- Package matmul_pkg holds:
  - dma_op_t {OP_LOAD_A, OP_LOAD_B, OP_STORE_C};
  - dma_state_t;
  - localparam BYTES_PER_WORD = 4.
- No sub-module is needed. Counters, address generation and the FSM stay in one module.

Test Plan:
- N=4, load_a at base 0x1000, zero waitrequest, readdata returns 2 cycles after issue: 16 reads at 0x1000..0x103C. buf_wr_addr 0..15 with buf_wr_sel=0. One dma_done pulse. busy drops the cycle after done.
- MAX_OUTSTANDING=2, readdatavalid delayed 6 cycles: issued - recvd never exceeds 2, and all 16 words land in order.
- store_c at base 0xFFFFFFF8 with random waitrequest: addresses wrap to 0x0..0x34. Write data matches C[0..15]. Address and data are stable during stalls. One done pulse.
- All three starts asserted in the same cycle: only load A runs. A load_b pulse mid-transfer is ignored, and the DDR model sees no B reads.
- rst asserted after 5 reads in load_b: next cycle all outputs are 0 and there is no done. A subsequent store_c runs cleanly and completes with one dma_done.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types for the matmul DMA responder: transfer op, FSM state and
// DDR word-address arithmetic.
package matmul_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_A,
        OP_LOAD_B,
        OP_STORE_C
    } dma_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WR_FETCH,
        ST_WR_DATA,
        ST_DONE
    } dma_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;

    // Byte address of word 'index' past 'base'; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
        return base + index * BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/matmul_dma.sv
// DMA responder: moves N*N 32-bit words between DDR (Avalon-MM master) and
// the on-chip A/B load buffers or the C store buffer, one transfer at a time.
module matmul_dma
    import matmul_pkg::*;
#(
    parameter int N               = 16,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dma_start_load_a,
    input  logic                     dma_start_load_b,
    input  logic                     dma_start_store_c,
    input  logic [31:0]              dma_addr_a,
    input  logic [31:0]              dma_addr_b,
    input  logic [31:0]              dma_addr_c,
    output logic                     dma_done,
    output logic                     dma_busy,
    output logic [31:0]              avm_address,
    output logic                     avm_read,
    output logic                     avm_write,
    output logic [DATA_W-1:0]        avm_writedata,
    input  logic                     avm_waitrequest,
    input  logic [DATA_W-1:0]        avm_readdata,
    input  logic                     avm_readdatavalid,
    output logic                     buf_wr_en,
    output logic                     buf_wr_sel,
    output logic [$clog2(N*N)-1:0]   buf_wr_addr,
    output logic [DATA_W-1:0]        buf_wr_data,
    output logic [$clog2(N*N)-1:0]   c_rd_addr,
    input  logic [DATA_W-1:0]        c_rd_data
);

    localparam int                 ADDR_W  = $clog2(N*N);
    localparam int                 COUNT_W = $clog2(N*N+1);
    localparam logic [COUNT_W-1:0] TOTAL   = COUNT_W'(N*N);
    localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(N*N-1);
    localparam logic [31:0]        MAX_OUT = 32'(MAX_OUTSTANDING);

    dma_state_t         state, state_next;
    dma_op_t            op;
    logic [31:0]        base;
    logic [COUNT_W-1:0] issued, recvd, sent;
    logic [DATA_W-1:0]  wdata;
    logic               wr_first;

    logic               start_any;
    dma_op_t            start_op;
    logic [31:0]        start_base;
    logic [COUNT_W-1:0] in_flight;
    logic               rd_req, rd_fire, rd_ret, wr_fire;

    // Fixed priority among simultaneous starts: load A, then load B, then store C.
    always_comb begin
        start_any  = dma_start_load_a | dma_start_load_b | dma_start_store_c;
        start_op   = OP_LOAD_A;
        start_base = dma_addr_a;
        if (dma_start_load_a) begin
            start_op   = OP_LOAD_A;
            start_base = dma_addr_a;
        end else if (dma_start_load_b) begin
            start_op   = OP_LOAD_B;
            start_base = dma_addr_b;
        end else if (dma_start_store_c) begin
            start_op   = OP_STORE_C;
            start_base = dma_addr_c;
        end
    end

    assign in_flight = issued - recvd;
    assign rd_req    = (state == ST_READ) && (issued < TOTAL) && (32'(in_flight) < MAX_OUT);
    assign rd_fire   = rd_req && !avm_waitrequest;
    assign rd_ret    = (state == ST_READ) && avm_readdatavalid;
    assign wr_fire   = (state == ST_WR_DATA) && !avm_waitrequest;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: each combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (start_any) state_next = (start_op == OP_STORE_C) ? ST_WR_FETCH : ST_READ;
            ST_READ:     if (rd_ret && recvd == LAST) state_next = ST_DONE;
            ST_WR_FETCH: state_next = ST_WR_DATA;
            ST_WR_DATA:  if (wr_fire) state_next = (sent == LAST) ? ST_DONE : ST_WR_FETCH;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op       <= OP_LOAD_A;
            base     <= '0;
            issued   <= '0;
            recvd    <= '0;
            sent     <= '0;
            wdata    <= '0;
            wr_first <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_any) begin
                        op     <= start_op;
                        base   <= start_base & ~32'h3;
                        issued <= '0;
                        recvd  <= '0;
                        sent   <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_fire) issued <= issued + 1'b1;
                    if (rd_ret)  recvd  <= recvd + 1'b1;
                end
                ST_WR_FETCH: wr_first <= 1'b1;
                ST_WR_DATA: begin
                    // C buffer data is only valid in the first WR_DATA cycle; hold it for stalls.
                    wr_first <= 1'b0;
                    if (wr_first) wdata <= c_rd_data;
                    if (wr_fire)  sent  <= sent + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low during reset so bus requests drop in the reset cycle itself.
    always_comb begin
        dma_done      = 1'b0;
        dma_busy      = 1'b0;
        avm_address   = '0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        buf_wr_en     = 1'b0;
        buf_wr_sel    = 1'b0;
        buf_wr_addr   = '0;
        buf_wr_data   = '0;
        c_rd_addr     = '0;
        if (!rst) begin
            dma_busy = (state != ST_IDLE);
            case (state)
                ST_READ: begin
                    avm_read    = rd_req;
                    avm_address = word_addr(base, 32'(issued));
                    if (avm_readdatavalid) begin
                        buf_wr_en   = 1'b1;
                        buf_wr_sel  = (op == OP_LOAD_B);
                        buf_wr_addr = recvd[ADDR_W-1:0];
                        buf_wr_data = avm_readdata;
                    end
                end
                ST_WR_FETCH: c_rd_addr = sent[ADDR_W-1:0];
                ST_WR_DATA: begin
                    avm_write     = 1'b1;
                    avm_address   = word_addr(base, 32'(sent));
                    avm_writedata = wr_first ? c_rd_data : wdata;
                end
                ST_DONE: dma_done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_dma.sv
// Randomized scoreboard bench for matmul_dma: a DDR/C-buffer responder, a
// transfer-level reference model and a decoupled output monitor.
module tb_matmul_dma;
    import matmul_pkg::*;

    localparam int N  = 4;
    localparam int NN = N * N;
    localparam int MO = 2;
    localparam int AW = $clog2(NN);

    logic          clk = 1'b0;
    logic          rst;
    logic          dma_start_load_a, dma_start_load_b, dma_start_store_c;
    logic [31:0]   dma_addr_a, dma_addr_b, dma_addr_c;
    logic          dma_done, dma_busy;
    logic [31:0]   avm_address;
    logic          avm_read, avm_write;
    logic [31:0]   avm_writedata;
    logic          avm_waitrequest;
    logic [31:0]   avm_readdata;
    logic          avm_readdatavalid;
    logic          buf_wr_en, buf_wr_sel;
    logic [AW-1:0] buf_wr_addr;
    logic [31:0]   buf_wr_data;
    logic [AW-1:0] c_rd_addr;
    logic [31:0]   c_rd_data;

    always #5 clk = ~clk;

    matmul_dma #(.N(N), .DATA_W(32), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst),
        .dma_start_load_a(dma_start_load_a), .dma_start_load_b(dma_start_load_b),
        .dma_start_store_c(dma_start_store_c),
        .dma_addr_a(dma_addr_a), .dma_addr_b(dma_addr_b), .dma_addr_c(dma_addr_c),
        .dma_done(dma_done), .dma_busy(dma_busy),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .buf_wr_en(buf_wr_en), .buf_wr_sel(buf_wr_sel), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data), .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data)
    );

    typedef struct { logic sel; logic [AW-1:0] idx; logic [31:0] data; } buf_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;

    buf_exp_t    exp_buf[$];
    logic [31:0] exp_rd[$];
    wr_exp_t     exp_wr[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] c_mem[NN];

    int checks = 0, errors = 0;
    int cyc = 0, rd_lat = 2;
    bit wait_rand = 0;
    int done_count = 0, exp_done = 0;
    int out_cnt = 0, max_out = 0, rd_handshakes = 0, b_reads = 0;
    bit model_busy = 0, both_seen = 0, stall_prev = 0, prev_done = 0;
    logic [31:0] held_addr, held_data;
    logic [31:0] b_lo = 32'h0000_8000;

    // DDR contents are a fixed hash of the byte address.
    function automatic logic [31:0] ddr_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives a one-cycle start pulse and, if the model says the block is idle,
    // queues the full expected transfer.
    task automatic issue_start(input bit a, input bit b, input bit c,
                               input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc);
        logic [31:0] base;
        buf_exp_t    be;
        wr_exp_t     we;
        @(posedge clk); #1;
        dma_start_load_a = a; dma_start_load_b = b; dma_start_store_c = c;
        dma_addr_a = ba; dma_addr_b = bb; dma_addr_c = bc;
        if (!model_busy && (a || b || c)) begin
            model_busy = 1;
            exp_done++;
            if (a || b) begin
                base = (a ? ba : bb) & 32'hFFFF_FFFC;
                for (int i = 0; i < NN; i++) begin
                    exp_rd.push_back(base + 32'(4 * i));
                    be.sel  = !a;
                    be.idx  = AW'(i);
                    be.data = ddr_word(base + 32'(4 * i));
                    exp_buf.push_back(be);
                end
            end else begin
                base = bc & 32'hFFFF_FFFC;
                for (int i = 0; i < NN; i++) begin
                    we.addr = base + 32'(4 * i);
                    we.data = c_mem[i];
                    exp_wr.push_back(we);
                end
            end
        end
        @(posedge clk); #1;
        dma_start_load_a = 0; dma_start_load_b = 0; dma_start_store_c = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_count < exp_done && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done_count"}, done_count, exp_done);
        repeat (4) @(posedge clk);
        check({name, "_no_extra_done"}, done_count, exp_done);
        check({name, "_rd_left"}, exp_rd.size(), 0);
        check({name, "_buf_left"}, exp_buf.size(), 0);
        check({name, "_wr_left"}, exp_wr.size(), 0);
        check({name, "_outstanding_cap"}, max_out <= MO, 1);
        check({name, "_rd_wr_exclusive"}, both_seen, 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctrl"}, {dma_done, dma_busy, avm_read, avm_write, buf_wr_en, buf_wr_sel}, 0);
        check({name, "_avm_address"}, avm_address, 0);
        check({name, "_avm_writedata"}, avm_writedata, 0);
        check({name, "_buf_wr"}, {buf_wr_addr, buf_wr_data}, 0);
        check({name, "_c_rd_addr"}, c_rd_addr, 0);
    endtask

    // DDR read responder and synchronous C buffer (1-cycle read latency).
    initial begin
        logic [AW-1:0] c_addr_s;
        avm_waitrequest = 0; avm_readdata = 0; avm_readdatavalid = 0; c_rd_data = 0;
        forever begin
            @(negedge clk);
            if (!rst && avm_read && !avm_waitrequest) begin
                pend_addr.push_back(avm_address);
                pend_due.push_back(cyc + rd_lat);
                if (avm_address >= b_lo && avm_address < b_lo + 32'd64) b_reads++;
            end
            c_addr_s = c_rd_addr;
            @(posedge clk); #1;
            cyc++;
            avm_waitrequest = wait_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
            c_rd_data = c_mem[c_addr_s];
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                avm_readdatavalid = 1;
                avm_readdata      = ddr_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                avm_readdatavalid = 0;
                avm_readdata      = $urandom;
            end
        end
    end

    // Monitor: compares every bus/buffer event against the scoreboard queues.
    initial begin
        buf_exp_t be;
        wr_exp_t  we;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
                prev_done  = 0;
            end else begin
                if (avm_read && avm_write) both_seen = 1;
                if (avm_read && !avm_waitrequest) begin
                    rd_handshakes++;
                    out_cnt++;
                    check("rd_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0) check("rd_addr", avm_address, exp_rd.pop_front());
                end
                if (buf_wr_en) begin
                    out_cnt--;
                    check("buf_expected", exp_buf.size() != 0, 1);
                    if (exp_buf.size() != 0) begin
                        be = exp_buf.pop_front();
                        check("buf_wr", {buf_wr_sel, buf_wr_addr, buf_wr_data}, {be.sel, be.idx, be.data});
                    end
                end
                if (out_cnt > max_out) max_out = out_cnt;
                if (stall_prev) begin
                    check("wr_held", avm_write, 1);
                    check("wr_addr_stable", avm_address, held_addr);
                    check("wr_data_stable", avm_writedata, held_data);
                end
                stall_prev = 0;
                if (avm_write) begin
                    if (!avm_waitrequest) begin
                        check("wr_expected", exp_wr.size() != 0, 1);
                        if (exp_wr.size() != 0) begin
                            we = exp_wr.pop_front();
                            check("wr_addr", avm_address, we.addr);
                            check("wr_data", avm_writedata, we.data);
                        end
                    end else begin
                        held_addr  = avm_address;
                        held_data  = avm_writedata;
                        stall_prev = 1;
                    end
                end
                if (prev_done) check("busy_after_done", dma_busy, 0);
                if (dma_done) begin
                    done_count++;
                    check("busy_in_done", dma_busy, 1);
                    model_busy = 0;
                end
                prev_done = dma_done;
            end
        end
    end

    initial begin
        int rd_start, n;
        rst = 1;
        dma_start_load_a = 0; dma_start_load_b = 0; dma_start_store_c = 0;
        dma_addr_a = 0; dma_addr_b = 0; dma_addr_c = 0;
        for (int i = 0; i < NN; i++) c_mem[i] = $urandom;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check_outputs_zero("idle");

        // Load A, 2-cycle read latency.
        rd_lat = 2; max_out = 0;
        issue_start(1, 0, 0, 32'h0000_1000, 0, 0);
        wait_done("load_a", 1000);

        // Load B with long latency: outstanding cap must be reached, never exceeded.
        rd_lat = 6; max_out = 0;
        issue_start(0, 1, 0, 0, {4'h0, 28'($urandom)} | 32'h3, 0);
        wait_done("load_b_lat6", 2000);
        check("load_b_cap_reached", max_out, MO);

        // Store C across the top of the address space with random stalls.
        rd_lat = 2; max_out = 0; wait_rand = 1;
        for (int i = 0; i < NN; i++) c_mem[i] = $urandom;
        issue_start(0, 0, 1, 0, 0, 32'hFFFF_FFF8);
        wait_done("store_c_wrap", 2000);
        wait_rand = 0;

        // Simultaneous starts, then a load_b pulse while busy.
        b_reads = 0; max_out = 0;
        issue_start(1, 1, 1, 32'h0000_4000, b_lo, 32'h0000_C000);
        repeat (4) @(posedge clk);
        issue_start(0, 1, 0, 0, b_lo, 0);
        wait_done("priority", 1000);
        check("priority_no_b_reads", b_reads, 0);

        // Reset after five reads of a load B.
        rd_start = rd_handshakes;
        issue_start(0, 1, 0, 0, 32'h0000_5000, 0);
        n = 0;
        while (rd_handshakes - rd_start < 5 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_five_reads", rd_handshakes - rd_start, 5);
        rst = 1;
        exp_rd.delete(); exp_buf.delete(); exp_wr.delete();
        out_cnt = 0; model_busy = 0; exp_done = done_count;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check_outputs_zero("after_reset");
        repeat (12) @(posedge clk);
        check("rst_no_done", done_count, exp_done);

        max_out = 0; wait_rand = 1;
        for (int i = 0; i < NN; i++) c_mem[i] = $urandom;
        issue_start(0, 0, 1, 0, 0, 32'h0000_0100);
        wait_done("store_after_rst", 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
